keypad_scan_debounce: RTL and testbench

//   Front end for the 4x4 score keypad. Drives the column strobes, samples the rows and

---
 rtl/keypad_scan_debounce_if.sv | 23 ++
 rtl/keypad_scan_debounce.sv | 148 ++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_debounce_if.sv
`default_nettype none
// ------------------------------------------------------------------
// keypad_scan_debounce_if : keypad matrix lines and key event outputs
// Rev 1.0
// ------------------------------------------------------------------
interface keypad_scan_debounce_if;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  modport master (
    input  key_row,
    output key_col, key_valid, key_code, key_held
  );

  modport slave (
    output key_row,
    input  key_col, key_valid, key_code, key_held
  );
endinterface
`default_nettype wire

// File: rtl/keypad_scan_debounce.sv
`default_nettype none
// ------------------------------------------------------------------
// keypad_scan_debounce : 4x4 column scan, per-frame debounce, one event per press
// Rev 1.0
// ------------------------------------------------------------------
module keypad_scan_debounce #(
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE_N = 4
) (
  input  wire logic               clk_in,
  input  wire logic               rst_n,
  keypad_scan_debounce_if.master  kp
);
  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STAB_W = $clog2(DEBOUNCE_N + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(DEBOUNCE_N);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } state_t;

  // Reset asserts asynchronously but releases on a clock edge
  logic [1:0] rst_sync_q;
  logic       rst_core_n;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_core_n = rst_sync_q[1];

  logic [3:0]        row_meta_q, row_sync_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        col_q, col_d;
  logic [15:0]       snap_q, snap_d;
  logic [4:0]        prev_cls_q, prev_cls_d;
  logic [STAB_W-1:0] stable_q, stable_d;
  state_t            state_q, state_d;
  logic              armed_q, armed_d;
  logic              valid_q, valid_d;
  logic [3:0]        code_q, code_d;
  logic              held_q, held_d;

  logic        tick, frame_end, is_stable;
  logic [15:0] frame_snap;
  logic [4:0]  hits;
  logic [3:0]  idx;
  logic [4:0]  cls;

  always_comb begin
    tick      = (slot_q == SLOT_LAST);
    frame_end = tick && (col_q == 2'd3);
    slot_d    = tick ? '0 : slot_q + SLOT_W'(1);
    col_d     = tick ? col_q + 2'd1 : col_q;

    frame_snap = snap_q;
    frame_snap[{col_q, 2'b00} +: 4] = ~row_sync_q;
    snap_d = tick ? frame_snap : snap_q;

    hits = '0;
    idx  = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_snap[i]) begin
        hits = hits + 5'd1;
        idx  = 4'(i);
      end
    end
    // {hit, index}; all-zero encodes NONE, including multi-key frames
    cls = (hits == 5'd1) ? {1'b1, idx} : 5'b0;

    prev_cls_d = prev_cls_q;
    stable_d   = stable_q;
    if (frame_end) begin
      prev_cls_d = cls;
      if (cls != prev_cls_q)        stable_d = STAB_W'(1);
      else if (stable_q != STAB_MAX) stable_d = stable_q + STAB_W'(1);
    end
    is_stable = frame_end && (stable_d == STAB_MAX);

    state_d = state_q;
    armed_d = armed_q;
    valid_d = 1'b0;
    code_d  = code_q;
    held_d  = held_q;
    case (state_q)
      ST_IDLE: begin
        if (is_stable) begin
          if (!cls[4]) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = ST_PRESSED;
            armed_d = 1'b0;
            valid_d = 1'b1;
            code_d  = cls[3:0];
            held_d  = 1'b1;
          end
        end
      end
      ST_PRESSED: begin
        // A different stable key drops to IDLE disarmed: it must be released first
        if (is_stable && (!cls[4] || cls[3:0] != code_q)) begin
          state_d = ST_IDLE;
          held_d  = 1'b0;
          armed_d = !cls[4];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_core_n) begin
    if (!rst_core_n) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      slot_q     <= '0;
      col_q      <= 2'd0;
      snap_q     <= '0;
      prev_cls_q <= '0;
      stable_q   <= '0;
      state_q    <= ST_IDLE;
      armed_q    <= 1'b1;
      valid_q    <= 1'b0;
      code_q     <= '0;
      held_q     <= 1'b0;
    end else begin
      row_meta_q <= kp.key_row;
      row_sync_q <= row_meta_q;
      slot_q     <= slot_d;
      col_q      <= col_d;
      snap_q     <= snap_d;
      prev_cls_q <= prev_cls_d;
      stable_q   <= stable_d;
      state_q    <= state_d;
      armed_q    <= armed_d;
      valid_q    <= valid_d;
      code_q     <= code_d;
      held_q     <= held_d;
    end
  end

  assign kp.key_col   = ~(4'b0001 << col_q);
  assign kp.key_valid = valid_q;
  assign kp.key_code  = code_q;
  assign kp.key_held  = held_q;
endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_debounce.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_keypad_scan_debounce : keypad matrix model with frame-aligned vector table
// Rev 1.0
// ------------------------------------------------------------------
module tb_keypad_scan_debounce;
  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE_N = 2;

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          pulses;
    int          held;
    int          code;
    string       name;
  } vec_t;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic [15:0] keys   = '0;
  int          checks = 0;
  int          errors = 0;
  int          total_pulses = 0;
  int          last_pulse_code = 0;
  vec_t        tbl[$];

  keypad_scan_debounce_if kif();

  keypad_scan_debounce #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_N(DEBOUNCE_N)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .kp     (kif.master)
  );

  always #5 clk_in = ~clk_in;

  // Matrix: a closed key pulls its row low while its column is strobed
  always_comb begin
    kif.key_row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!kif.key_col[c])
        for (int r = 0; r < 4; r++)
          if (keys[c*4 + r]) kif.key_row[r] = 1'b0;
  end

  always @(negedge clk_in) begin
    if (kif.key_valid === 1'b1) begin
      total_pulses++;
      last_pulse_code = int'(kif.key_code);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Returns #1 after the first negedge following a frame end
  task automatic next_frame();
    int n;
    n = 0;
    while (kif.key_col !== 4'b0111 && n < 40) begin @(negedge clk_in); n++; end
    while (kif.key_col !== 4'b1110 && n < 40) begin @(negedge clk_in); n++; end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL frame_sync: key_col stuck at %b", kif.key_col);
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    logic [3:0] exp_col;

    tbl.push_back('{16'h0200, 1, 0, 0, 0,  "press9_f1"});
    tbl.push_back('{16'h0200, 1, 1, 1, 9,  "press9_f2"});
    tbl.push_back('{16'h0200, 3, 0, 1, 9,  "hold9_norepeat"});
    tbl.push_back('{16'h0000, 1, 0, 1, 9,  "rel9_f1"});
    tbl.push_back('{16'h0000, 1, 0, 0, 9,  "rel9_f2"});
    for (int t = 0; t < 3; t++) begin
      tbl.push_back('{16'h0040, 1, 0, 0, 9, "toggle6_on"});
      tbl.push_back('{16'h0000, 1, 0, 0, 9, "toggle6_off"});
    end
    tbl.push_back('{16'h0040, 1, 0, 0, 9,  "steady6_f1"});
    tbl.push_back('{16'h0040, 1, 1, 1, 6,  "steady6_f2"});
    tbl.push_back('{16'h0000, 2, 0, 0, 6,  "rel6"});
    tbl.push_back('{16'h8001, 3, 0, 0, 6,  "dual_0_15"});
    tbl.push_back('{16'h0001, 1, 0, 0, 6,  "only0_f1"});
    tbl.push_back('{16'h0001, 1, 1, 1, 0,  "only0_f2"});
    tbl.push_back('{16'h0000, 2, 0, 0, 0,  "rel0"});
    tbl.push_back('{16'h0020, 2, 1, 1, 5,  "press5"});
    tbl.push_back('{16'h0400, 1, 0, 1, 5,  "switch10_f1"});
    tbl.push_back('{16'h0400, 1, 0, 0, 5,  "switch10_f2"});
    tbl.push_back('{16'h0400, 3, 0, 0, 5,  "hold10_locked"});
    tbl.push_back('{16'h0000, 2, 0, 0, 5,  "gap"});
    tbl.push_back('{16'h0400, 2, 1, 1, 10, "repress10"});
    tbl.push_back('{16'h0000, 2, 0, 0, 10, "rel10"});

    // Reset state
    repeat (4) @(negedge clk_in);
    #1;
    check("rst_col",   int'(kif.key_col),   14);
    check("rst_valid", int'(kif.key_valid), 0);
    check("rst_code",  int'(kif.key_code),  0);
    check("rst_held",  int'(kif.key_held),  0);
    rst_n = 1'b1;

    // Column rotation with no keys
    next_frame();
    for (int i = 0; i < 16; i++) begin
      exp_col = ~(4'b0001 << (i / 4));
      check("col_rotate", int'(kif.key_col), int'(exp_col));
      @(negedge clk_in);
      #1;
    end
    repeat (3) next_frame();
    check("idle_no_pulse", total_pulses, 0);

    // Table of frame-aligned vectors
    foreach (tbl[v]) begin
      keys = tbl[v].keys;
      snap = total_pulses;
      repeat (tbl[v].frames) next_frame();
      check({tbl[v].name, "_pulses"}, total_pulses - snap, tbl[v].pulses);
      check({tbl[v].name, "_held"},   int'(kif.key_held), tbl[v].held);
      check({tbl[v].name, "_code"},   int'(kif.key_code), tbl[v].code);
      if (tbl[v].pulses > 0)
        check({tbl[v].name, "_evcode"}, last_pulse_code, tbl[v].code);
    end

    // Reset while a key is held mid-frame
    keys = 16'h0020;
    snap = total_pulses;
    repeat (2) next_frame();
    check("k5_pulse", total_pulses - snap, 1);
    check("k5_held",  int'(kif.key_held), 1);
    next_frame();
    repeat (5) @(negedge clk_in);
    rst_n = 1'b0;
    #1;
    check("midrst_col",   int'(kif.key_col),   14);
    check("midrst_valid", int'(kif.key_valid), 0);
    check("midrst_held",  int'(kif.key_held),  0);
    check("midrst_code",  int'(kif.key_code),  0);
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    snap = total_pulses;
    next_frame();
    check("post_rst_f1_pulse", total_pulses - snap, 0);
    check("post_rst_f1_held",  int'(kif.key_held), 0);
    next_frame();
    check("post_rst_f2_pulse", total_pulses - snap, 1);
    check("post_rst_f2_code",  int'(kif.key_code), 5);
    check("post_rst_f2_held",  int'(kif.key_held), 1);
    repeat (3) next_frame();
    check("post_rst_norepeat", total_pulses - snap, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
